// File: rtl/ahbl_bus_pkg.sv
// Shared AHB-Lite encodings, default-slave state type and the decode priority helper
// used by ahbl_bus_mux_n and ahbl_default_slave.
package ahbl_bus_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int MAX_SLAVES = 16;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    // Keeps only the lowest set bit, so overlapping address windows resolve to one slave.
    function automatic logic [MAX_SLAVES-1:0] lowest_onehot(input logic [MAX_SLAVES-1:0] req);
        return req & (~req + MAX_SLAVES'(1));
    endfunction

endpackage

// File: rtl/ahbl_default_slave.sv
// Default slave for unmapped accesses: two-cycle ERROR state machine, plus the stall
// watchdog that forces the same ERROR when AHBL_BUS_TIMEOUT_EN is defined.
module ahbl_default_slave
    import ahbl_bus_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] htrans,
    input  logic       hready,
    input  logic       unmapped,
    input  logic       stall,
    input  logic       to_clr,
    output logic       hreadyout,
    output logic       hresp,
    output logic       to_flag,
    output logic       abort
);

    ds_state_t state;
    ds_state_t state_next;
    logic      active;

    always_comb begin
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = unmapped;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
    end

`ifdef AHBL_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] stall_count;

    assign abort = stall && (stall_count == CW'(TIMEOUT - 1));

    // A fresh timeout outranks a simultaneous clear so the event is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            to_flag     <= 1'b0;
        end else begin
            if (hready || abort)
                stall_count <= '0;
            else if (stall)
                stall_count <= stall_count + 1'b1;
            if (abort)
                to_flag <= 1'b1;
            else if (to_clr)
                to_flag <= 1'b0;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = stall ^ to_clr ^ (TIMEOUT > 0);
    assign abort          = 1'b0;
    assign to_flag        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= DS_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DS_IDLE: if (hready && active) state_next = DS_ERR1;
            DS_ERR1: state_next = DS_ERR2;
            DS_ERR2: state_next = (hready && active) ? DS_ERR1 : DS_IDLE;
            default: state_next = DS_IDLE;
        endcase
        if (abort)
            state_next = DS_ERR1;
    end

    // Outputs depend on state only, keeping HREADY free of combinational feedback.
    assign hreadyout = (state != DS_ERR1);
    assign hresp     = (state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahbl_bus_mux_n.sv
// AHB-Lite single-master interconnect: address decoder, data-phase response mux and
// default slave. Define AHBL_BUS_TIMEOUT_EN to enable the slave stall watchdog.
module ahbl_bus_mux_n
    import ahbl_bus_pkg::*;
#(
    parameter int               NS      = 4,
    parameter int               AW      = 32,
    parameter int               DW      = 64,
    parameter int               MW      = 8,
    parameter logic [NS*MW-1:0] S_BASE  = {NS{8'h00}},
    parameter logic [NS*MW-1:0] S_MASK  = {NS{8'hFF}},
    parameter int               TIMEOUT = 1023
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [AW-1:0]    HADDR,
    input  logic [1:0]       HTRANS,
    output logic             HREADY,
    output logic [DW-1:0]    HRDATA,
    output logic             HRESP,
    output logic [NS-1:0]    HSEL_S,
    input  logic [NS*DW-1:0] HRDATA_S,
    input  logic [NS-1:0]    HREADYOUT_S,
    input  logic [NS-1:0]    HRESP_S,
    output logic             TO_FLAG,
    input  logic             TO_CLR
);

    localparam int            IW = $clog2(NS + 1);
    localparam logic [IW-1:0] DS = IW'(NS);

    logic [MW-1:0]         addr_top;
    logic [NS-1:0]         match;
    logic [MAX_SLAVES-1:0] grant;
    logic [IW-1:0]         dec_idx;
    logic [IW-1:0]         dsel;
    logic                  unmapped;
    logic                  ds_ready;
    logic                  ds_resp;
    logic                  stall;
    logic                  abort;
    logic                  unused_addr;

    assign addr_top    = HADDR[AW-1 -: MW];
    assign unused_addr = ^HADDR[AW-MW-1:0];

    for (genvar i = 0; i < NS; i++) begin : g_match
        assign match[i] = (addr_top & S_MASK[i*MW +: MW]) == (S_BASE[i*MW +: MW] & S_MASK[i*MW +: MW]);
    end

    assign grant    = lowest_onehot(MAX_SLAVES'(match));
    assign HSEL_S   = grant[NS-1:0];
    assign unmapped = ~|match;

    if (NS < MAX_SLAVES) begin : g_grant_pad
        logic unused_grant;
        assign unused_grant = ^grant[MAX_SLAVES-1:NS];
    end

    always_comb begin
        dec_idx = DS;
        for (int i = 0; i < NS; i++)
            if (grant[i])
                dec_idx = IW'(i);
    end

    // The data-phase target only advances when the current data phase completes.
    always_ff @(posedge HCLK) begin
        if (HRESET)
            dsel <= DS;
        else if (abort)
            dsel <= DS;
        else if (HREADY)
            dsel <= dec_idx;
    end

    always_comb begin
        HREADY = ds_ready;
        HRESP  = ds_resp;
        HRDATA = '0;
        stall  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (dsel == IW'(i)) begin
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
                HRDATA = HRDATA_S[i*DW +: DW];
                stall  = !HREADYOUT_S[i];
            end
        end
    end

    ahbl_default_slave #(
        .TIMEOUT (TIMEOUT)
    ) u_default_slave (
        .clk       (HCLK),
        .reset     (HRESET),
        .htrans    (HTRANS),
        .hready    (HREADY),
        .unmapped  (unmapped),
        .stall     (stall),
        .to_clr    (TO_CLR),
        .hreadyout (ds_ready),
        .hresp     (ds_resp),
        .to_flag   (TO_FLAG),
        .abort     (abort)
    );

endmodule
